// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//
// Holds the register-file geometry, the requester-ID encoding and a small
// saturating-increment helper used by the r0 drop counter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 8;

    // Requester identity; also the encoding of the round-robin state.
    typedef enum logic {
        ReqAlu = 1'b0,
        ReqMem = 1'b1
    } req_id_e;

    // One writeback request as seen by the arbiter.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    // Increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        result = value;
        if (value != {CNT_W{1'b1}}) begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_onehot_decode.sv
// One-hot write-select decoder for the register file.
//
// Converts a register index plus enable into a one-hot select vector. Bit 0
// is never driven because register 0 is hard-wired and must not be written.
//
// Ports:
//   idx     - register index
//   en      - decode enable; all-zero output when low
//   onehot  - one-hot register select (bit n selects register n)
module wb_onehot_decode
    import regfile_wb_arbiter_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [REG_COUNT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && (idx != '0)) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
//
// Merges the ALU and load writeback ports onto the single register-file write
// port. Requests use a valid/ready handshake; ready is combinational. Accepted
// writes appear on dselect/dbus/wb_rd/wb_busy exactly one cycle later for one
// cycle. Writes to register 0 are accepted but suppressed and counted in a
// saturating counter.
//
// Configuration macro:
//   WB_ROUND_ROBIN_EN - defined: contended cycles alternate between requesters
//                       (first contended grant goes to MEM).
//                       undefined: MEM always wins contention.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   alu_valid/rd/data/ready - ALU writeback request port
//   mem_valid/rd/data/ready - load writeback request port
//   dselect                 - one-hot register write select
//   dbus                    - write data shared by all registers
//   wb_busy                 - a register write is presented this cycle
//   wb_rd                   - register being written (0 when idle)
//   r0_drop_cnt             - saturating count of accepted writes to register 0
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,

    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,

    output logic [REG_COUNT-1:0] dselect,
    output logic [DATA_W-1:0]    dbus,
    output logic                 wb_busy,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [CNT_W-1:0]     r0_drop_cnt
);

    wb_req_t alu_req;
    wb_req_t mem_req;
    wb_req_t acc_req;

    logic    contend;
    logic    xfer;
    req_id_e winner;

    logic                 wb_valid_q;
    logic [REG_IDX_W-1:0] wb_rd_q;
    logic [DATA_W-1:0]    dbus_q;
    logic [CNT_W-1:0]     r0_cnt_q;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};

    assign contend = alu_req.valid & mem_req.valid;

    // ------------------------------------------------------------------
    // Contention policy
    // ------------------------------------------------------------------
`ifdef WB_ROUND_ROBIN_EN
    // Winner of the most recent contended cycle; uncontended grants leave it
    // untouched. Reset value ALU makes the first contended grant go to MEM.
    req_id_e last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ReqAlu;
        end else if (contend) begin
            last_q <= winner;
        end
    end

    always_comb begin
        winner = (last_q == ReqAlu) ? ReqMem : ReqAlu;
    end
`else
    assign winner = ReqMem;
`endif

    // ------------------------------------------------------------------
    // Grant / ready generation
    // ------------------------------------------------------------------
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        // Readies are held low during reset so nothing is accepted then.
        if (rst_n) begin
            if (contend) begin
                if (winner == ReqMem) begin
                    mem_ready = 1'b1;
                end else begin
                    alu_ready = 1'b1;
                end
            end else begin
                alu_ready = alu_req.valid;
                mem_ready = mem_req.valid;
            end
        end
    end

    assign xfer = alu_ready | mem_ready;

    always_comb begin
        acc_req = alu_req;
        if (mem_ready) begin
            acc_req = mem_req;
        end
    end

    // ------------------------------------------------------------------
    // Registered write stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            dbus_q     <= '0;
            r0_cnt_q   <= '0;
        end else begin
            // Register 0 writes are swallowed here: they never reach the
            // output stage as a busy cycle.
            wb_valid_q <= xfer && (acc_req.rd != '0);
            wb_rd_q    <= (xfer && (acc_req.rd != '0)) ? acc_req.rd : '0;
            if (xfer) begin
                dbus_q <= acc_req.data;
            end
            if (xfer && (acc_req.rd == '0)) begin
                r0_cnt_q <= sat_inc(r0_cnt_q);
            end
        end
    end

    wb_onehot_decode u_decode (
        .idx    (wb_rd_q),
        .en     (wb_valid_q),
        .onehot (dselect)
    );

    assign dbus        = dbus_q;
    assign wb_busy     = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign r0_drop_cnt = r0_cnt_q;

    // Both requesters must never be granted together.
    always_comb begin
        assert (!(alu_ready && mem_ready));
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 alu_valid  input  1  ALU writeback request.
REQ-004 alu_rd  input  5  ALU destination register index.
REQ-005 alu_data  input  32  ALU writeback value.
REQ-006 alu_ready  output  1  ALU request accepted this cycle.
REQ-007 mem_valid  input  1  load writeback request.
REQ-008 mem_rd  input  5  load destination register index.
REQ-009 mem_data  input  32  load writeback value.
REQ-010 mem_ready  output  1  load request accepted this cycle.
REQ-011 dselect  output  32  one-hot register write select, bit n drives register n's Dselect.
REQ-012 dbus  output  32  write data shared by all registers' D inputs.
REQ-013 wb_busy  output  1  a write is being presented on dselect/dbus this cycle.
REQ-014 wb_rd  output  5  index of the register being written; 0 when wb_busy low.
REQ-015 r0_drop_cnt  output  8  count of accepted writes targeting register 0, saturating at 255.

Function
REQ-016 Handshake: a transfer occurs when valid and ready are both high on a rising clk edge; ready is combinational from the valids and arbitration state.
REQ-017 A requester SHALL hold valid, rd and data stable from assertion until its transfer.
REQ-018 At most one of alu_ready, mem_ready is high in any cycle; a ready is never high without its valid.
REQ-019 When exactly one requester is valid, it SHALL be granted that cycle.
REQ-020 When both are valid, the winner SHALL be chosen per REQ-032/REQ-033.
REQ-021 Latency: an accepted request drives dselect/dbus/wb_rd/wb_busy in the following cycle only, for exactly one cycle (registered output stage).
REQ-022 Back-to-back: a new request may be accepted every cycle; sustained throughput is one write per cycle.
REQ-023 rd = 0: the request is accepted normally, but dselect SHALL be all-zero, wb_busy low and wb_rd 0 that cycle; r0_drop_cnt increments by 1 unless already 255.
REQ-024 rd != 0: dselect SHALL have exactly bit rd set; dbus carries the accepted data.
REQ-025 Idle cycles (no transfer): dselect = 0, wb_busy = 0, wb_rd = 0; dbus holds its last value.

Reset
REQ-026 While rst_n is low: alu_ready = 0, mem_ready = 0, dselect = 0, dbus = 0, wb_busy = 0, wb_rd = 0, r0_drop_cnt = 0.
REQ-027 Round-robin state resets to "last grant = ALU", so the first contended grant goes to MEM.
REQ-028 Reset asserted mid-write: dselect SHALL drop to 0 immediately (asynchronously); the in-flight write is lost and is not replayed.
REQ-029 Any request pending at reset is not accepted; it SHALL be granted normally after rst_n rises if still valid.
REQ-030 The first transfer is possible on the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 Macro WB_ROUND_ROBIN_EN selects the contention policy.
REQ-032 Defined: on contention, grant the requester not granted at the last contended cycle; the 1-bit state updates only on contended cycles.
REQ-033 Undefined: fixed priority, MEM always wins contention; no arbitration state flop exists.

Structure
REQ-034 Shared package holds REG_COUNT = 32, REG_IDX_W = 5, DATA_W = 32 and the requester-ID encoding (ALU = 0, MEM = 1).
REQ-035 One sub-module, wb_onehot_decode, converts a 5-bit index plus enable into the 32-bit one-hot dselect with bit 0 forced low.

Verification
REQ-036 alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle dselect=0x00000020, dbus=0xDEADBEEF, wb_busy=1, wb_rd=5.
REQ-037 Both valid (alu_rd=3, mem_rd=7), held 2 cycles -> with WB_ROUND_ROBIN_EN: grant MEM then ALU (dselect 0x80 then 0x08); without it: grant MEM and stall ALU while mem_valid stays high.
REQ-038 Write to rd=0 repeated 257 times -> dselect stays 0 and r0_drop_cnt ends at 255.
REQ-039 Continuous single-requester stream of rd=1..31 -> one write per cycle with the correct one-hot bit each cycle and no gaps.
REQ-040 rst_n pulled low in the cycle dselect=0x00000010 -> dselect goes to 0 without waiting for a clk edge; after release, a still-pending mem request is written in the second cycle after release.
